fsm3cycles_detect: RTL and testbench

FSM3CYCLES_DETECT -- requirements
Module: fsm3cycles_detect

---
 rtl/fsm3_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/fsm3cycles_detect.sv | 73 +++++++
 tb/tb_fsm3cycles_detect.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fsm3_pkg.sv
// Shared types and constants for the 3-cycle pulse detector.
package fsm3_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    H1   = 3'd1,
    H2   = 3'd2,
    H3   = 3'd3,
    LONG = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {width{1'b1}})) begin
      value <= value + width'(1);
    end
  end

endmodule

// File: rtl/fsm3cycles_detect.sv
// Classifies high runs on x: exactly 3 cycles -> det, 1-2 -> err_short, 4+ -> err_long.
module fsm3cycles_detect
  import fsm3_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             clr,
  output logic             det,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] det_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t state;
  state_t state_nxt;
  logic   det_nxt;
  logic   short_nxt;
  logic   long_nxt;
  logic   err_inc;

  // Next state plus the strobe that the falling edge of a run will register.
  always_comb begin
    state_nxt = IDLE;
    det_nxt   = 1'b0;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    unique case (state)
      IDLE: if (x) state_nxt = H1;
      H1:   if (x) state_nxt = H2;   else short_nxt = 1'b1;
      H2:   if (x) state_nxt = H3;   else short_nxt = 1'b1;
      H3:   if (x) state_nxt = LONG; else det_nxt   = 1'b1;
      LONG: if (x) state_nxt = LONG; else long_nxt  = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      det       <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_nxt;
      det       <= det_nxt;
      err_short <= short_nxt;
      err_long  <= long_nxt;
    end
  end

  assign err_inc = short_nxt | long_nxt;

  sat_counter #(.width(CNT_W)) u_det_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (det_nxt),
    .clr   (clr),
    .value (det_cnt)
  );

  sat_counter #(.width(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (err_inc),
    .clr   (clr),
    .value (err_cnt)
  );

endmodule

// File: tb/tb_fsm3cycles_detect.sv
// Scoreboard bench: stimulus predicts each strobe and counter values, monitor checks them.
module tb_fsm3cycles_detect;

  localparam int unsigned CNT_W = 8;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    int kind;   // 0 det, 1 short, 2 long
    int dcnt;
    int ecnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             x   = 1'b0;
  logic             clr = 1'b0;
  logic             det;
  logic             err_short;
  logic             err_long;
  logic [CNT_W-1:0] det_cnt;
  logic [CNT_W-1:0] err_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   run   = 0;
  int   det_m = 0;
  int   err_m = 0;

  fsm3cycles_detect #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .clr       (clr),
    .det       (det),
    .err_short (err_short),
    .err_long  (err_long),
    .det_cnt   (det_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Drive one sampled edge's worth of inputs and predict the outcome.
  task automatic step(input logic xv, input logic cv = 1'b0);
    exp_t e;
    x   = xv;
    clr = cv;
    if (!xv && run > 0) begin
      e.kind = (run == 3) ? 0 : (run < 3) ? 1 : 2;
      if (cv) begin
        det_m = 0;
        err_m = 0;
      end else if (e.kind == 0) begin
        if (det_m < MAXC) det_m++;
      end else begin
        if (err_m < MAXC) err_m++;
      end
      e.dcnt = det_m;
      e.ecnt = err_m;
      q.push_back(e);
      run = 0;
    end else begin
      if (xv) run++;
      if (cv) begin
        det_m = 0;
        err_m = 0;
      end
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
    step(1'b0);
  endtask

  // Monitor: every strobe must match the next queued prediction.
  always @(negedge clk) begin
    if (rst && (det || err_short || err_long)) begin
      exp_t e;
      int   k;
      checks++;
      if ((32'(det) + 32'(err_short) + 32'(err_long)) != 1) begin
        failures++;
        $display("FAIL onehot: actual det=%0b short=%0b long=%0b required exactly one",
                 det, err_short, err_long);
      end
      k = det ? 0 : err_short ? 1 : 2;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: actual kind=%0d required none", k);
      end else begin
        e = q.pop_front();
        check("strobe_kind", k, e.kind);
        check("det_cnt", int'(det_cnt), e.dcnt);
        check("err_cnt", int'(err_cnt), e.ecnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_det", int'(det), 0);
    check("reset_det_cnt", int'(det_cnt), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single valid pulse, short pulses, long pulse.
    step(1'b0);
    pulse(3);
    step(1'b0);
    pulse(1);
    pulse(2);
    step(1'b0);
    pulse(10);
    step(1'b0);
    check("after_basic_det_cnt", int'(det_cnt), 1);
    check("after_basic_err_cnt", int'(err_cnt), 3);

    // Back-to-back valid pulses with single low gaps.
    for (int i = 0; i < 5; i++) pulse(3);
    step(1'b0);
    check("b2b_det_cnt", int'(det_cnt), 6);

    // Saturation, then clear coincident with a det strobe.
    for (int i = 0; i < 260; i++) pulse(3);
    step(1'b0);
    check("sat_det_cnt", int'(det_cnt), MAXC);
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0, 1'b1);
    check("clr_det_cnt", int'(det_cnt), 0);
    check("clr_err_cnt", int'(err_cnt), 0);
    step(1'b0);

    // Error count nonzero before reset so the reset check is meaningful.
    pulse(1);
    step(1'b0);

    // Reset mid-pulse with x held high through release.
    step(1'b1);
    step(1'b1);
    #2;
    rst   = 1'b0;
    run   = 0;
    det_m = 0;
    err_m = 0;
    #1;
    check("midrst_det_cnt", int'(det_cnt), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    repeat (2) @(posedge clk);
    check("midrst_strobes", int'({det, err_short, err_long}), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    step(1'b0);
    check("post_rst_det_cnt", int'(det_cnt), 1);
    check("post_rst_err_cnt", int'(err_cnt), 0);

    repeat (3) step(1'b0);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
